// File: rtl/adma_dm_wr_sched_if.sv
// Signal bundle between the write scheduler, the per-channel request/data buffers,
// the AXI AW register and the W engine.
interface adma_dm_wr_sched_if #(
  parameter int CH_NUM         = 4,
  parameter int ATX_ADDR_W     = 32,
  parameter int ATX_LEN_W      = 8,
  parameter int ATX_DST_DATA_W = 256
);
  logic [CH_NUM-1:0]                ch_req_vld;
  logic [CH_NUM*ATX_ADDR_W-1:0]     ch_req_addr;
  logic [CH_NUM*ATX_LEN_W-1:0]      ch_req_len;
  logic [CH_NUM-1:0]                ch_req_rdy;
  logic [CH_NUM*ATX_DST_DATA_W-1:0] ch_wdata;
  logic [CH_NUM-1:0]                ch_wdata_vld;
  logic [CH_NUM-1:0]                ch_wdata_rdy;
  logic [ATX_ADDR_W-1:0]            m_awaddr_o;
  logic [ATX_LEN_W-1:0]             m_awlen_o;
  logic                             m_awvalid_o;
  logic                             m_awready_i;
  logic [ATX_LEN_W-1:0]             atx_awlen;
  logic                             atx_vld;
  logic                             atx_rdy;
  logic [ATX_DST_DATA_W-1:0]        atx_wdata;
  logic                             atx_wdata_vld;
  logic                             atx_wdata_rdy;
  logic                             wr_idle;

  modport master (
    input  ch_req_vld, ch_req_addr, ch_req_len, ch_wdata, ch_wdata_vld,
    input  m_awready_i, atx_rdy, atx_wdata_rdy,
    output ch_req_rdy, ch_wdata_rdy, m_awaddr_o, m_awlen_o, m_awvalid_o,
    output atx_awlen, atx_vld, atx_wdata, atx_wdata_vld, wr_idle
  );

  modport slave (
    output ch_req_vld, ch_req_addr, ch_req_len, ch_wdata, ch_wdata_vld,
    output m_awready_i, atx_rdy, atx_wdata_rdy,
    input  ch_req_rdy, ch_wdata_rdy, m_awaddr_o, m_awlen_o, m_awvalid_o,
    input  atx_awlen, atx_vld, atx_wdata, atx_wdata_vld, wr_idle
  );
endinterface

// File: rtl/adma_dm_wr_sched.sv
// DMA write scheduler: round-robin AW issue across channels, an order FIFO of
// {channel, len}, and in-order steering of channel data onto the shared W path.
module adma_dm_wr_sched #(
  parameter int CH_NUM         = 4,
  parameter int CH_ID_W        = 2,
  parameter int ATX_ADDR_W     = 32,
  parameter int ATX_LEN_W      = 8,
  parameter int ATX_DST_DATA_W = 256,
  parameter int ATX_NUM_OSTD   = 4
) (
  input logic                clk,
  input logic                rst_n,
  adma_dm_wr_sched_if.master bus
);
  localparam int PTR_W = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
  localparam int CNT_W = $clog2(ATX_NUM_OSTD + 1);

  typedef struct packed {
    logic [CH_ID_W-1:0]   id;
    logic [ATX_LEN_W-1:0] len;
  } ord_t;

  logic [CH_ID_W-1:0]   rr_ptr;
  logic [CH_ID_W-1:0]   gnt_id;
  logic                 aw_free;
  logic                 issue;
  ord_t                 ord_mem [ATX_NUM_OSTD];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     ord_cnt;
  logic                 fifo_full;
  ord_t                 head;
  logic                 hv;
  logic                 hs;
  logic                 last_beat;
  logic                 pop;
  logic [ATX_LEN_W-1:0] beat_cnt;

  function automatic logic [CH_ID_W-1:0] rr_idx(input logic [CH_ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CH_NUM) s -= CH_NUM;
    return CH_ID_W'(s);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ATX_NUM_OSTD - 1)) ? '0 : p + 1'b1;
  endfunction

  // Walk from the farthest offset back to rr_ptr so the last hit is the winner.
  always_comb begin
    gnt_id = rr_ptr;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (bus.ch_req_vld[rr_idx(rr_ptr, k)]) gnt_id = rr_idx(rr_ptr, k);
    end
  end

  assign fifo_full = (ord_cnt == CNT_W'(ATX_NUM_OSTD));
  assign aw_free   = !bus.m_awvalid_o || bus.m_awready_i;
  assign issue     = (|bus.ch_req_vld) && aw_free && bus.atx_rdy && !fifo_full;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.ch_req_rdy = '0;
    if (issue) bus.ch_req_rdy[gnt_id] = 1'b1;
  end

  assign bus.atx_vld   = issue;
  assign bus.atx_awlen = bus.ch_req_len[gnt_id*ATX_LEN_W +: ATX_LEN_W];

  assign head = ord_mem[rd_ptr];
  assign hv   = (ord_cnt != '0);

  assign bus.atx_wdata     = bus.ch_wdata[head.id*ATX_DST_DATA_W +: ATX_DST_DATA_W];
  assign bus.atx_wdata_vld = hv && bus.ch_wdata_vld[head.id];

  always_comb begin
    bus.ch_wdata_rdy = '0;
    if (hv && bus.atx_wdata_rdy) bus.ch_wdata_rdy[head.id] = 1'b1;
  end

  assign hs        = bus.atx_wdata_vld && bus.atx_wdata_rdy;
  assign last_beat = (beat_cnt == head.len);
  assign pop       = hs && last_beat;

  assign bus.wr_idle = !hv && !bus.m_awvalid_o;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_awvalid_o <= 1'b0;
      bus.m_awaddr_o  <= '0;
      bus.m_awlen_o   <= '0;
      rr_ptr          <= '0;
    end else if (issue) begin
      bus.m_awvalid_o <= 1'b1;
      bus.m_awaddr_o  <= bus.ch_req_addr[gnt_id*ATX_ADDR_W +: ATX_ADDR_W];
      bus.m_awlen_o   <= bus.atx_awlen;
      rr_ptr          <= (gnt_id == CH_ID_W'(CH_NUM - 1)) ? '0 : gnt_id + 1'b1;
    end else if (bus.m_awready_i) begin
      bus.m_awvalid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ord_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (issue) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      if (issue && !pop)      ord_cnt <= ord_cnt + 1'b1;
      else if (!issue && pop) ord_cnt <= ord_cnt - 1'b1;
      if (hs) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // NOTE: the order storage has no reset; entries are only read while ord_cnt
  // marks them valid, and ord_cnt itself is reset.
  always_ff @(posedge clk) begin
    if (issue) ord_mem[wr_ptr] <= '{id: gnt_id, len: bus.atx_awlen};
  end
endmodule

// File: tb/tb_adma_dm_wr_sched.sv
// Directed self-checking bench for adma_dm_wr_sched: reset, round-robin, ordering,
// outstanding limit, AW backpressure, W-engine full and mid-burst reset.
module tb_adma_dm_wr_sched;
  localparam int CH_NUM = 4;
  localparam int CH_ID_W = 2;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int DW = 256;
  localparam int OSTD = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adma_dm_wr_sched_if #(.CH_NUM(CH_NUM), .ATX_ADDR_W(AW), .ATX_LEN_W(LW),
                        .ATX_DST_DATA_W(DW)) bus ();

  adma_dm_wr_sched #(
    .CH_NUM(CH_NUM), .CH_ID_W(CH_ID_W), .ATX_ADDR_W(AW), .ATX_LEN_W(LW),
    .ATX_DST_DATA_W(DW), .ATX_NUM_OSTD(OSTD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return {8{32'hD000_0000 | 32'(i)}};
  endfunction

  function automatic logic [3:0] onehot(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_len(input int ch, input logic [LW-1:0] len);
    bus.ch_req_len[ch*LW +: LW] = len;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_awvalid"}, bus.m_awvalid_o, 1'b0);
    check({pfx, "_awaddr"}, bus.m_awaddr_o, '0);
    check({pfx, "_awlen"}, bus.m_awlen_o, '0);
    check({pfx, "_atx_vld"}, bus.atx_vld, 1'b0);
    check({pfx, "_wdata_vld"}, bus.atx_wdata_vld, 1'b0);
    check({pfx, "_req_rdy"}, bus.ch_req_rdy, 4'b0000);
    check({pfx, "_wdata_rdy"}, bus.ch_wdata_rdy, 4'b0000);
    check({pfx, "_idle"}, bus.wr_idle, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    bus.ch_req_vld    = '0;
    bus.ch_wdata_vld  = '0;
    bus.m_awready_i   = 1'b1;
    bus.atx_rdy       = 1'b1;
    bus.atx_wdata_rdy = 1'b1;
    for (int i = 0; i < CH_NUM; i++) begin
      bus.ch_req_addr[i*AW +: AW] = addr_of(i);
      bus.ch_wdata[i*DW +: DW]    = data_of(i);
      set_len(i, 8'd0);
    end
    #2;
    check_reset("por");
    tick();
    rst_n = 1'b1;
    tick();

    // Round-robin: all channels, len=0, one grant per cycle.
    bus.ch_req_vld   = 4'hF;
    bus.ch_wdata_vld = 4'hF;
    for (int k = 0; k < 8; k++) begin
      settle();
      check($sformatf("rr_gnt%0d", k), bus.ch_req_rdy, onehot(k % 4));
      check($sformatf("rr_atx_vld%0d", k), bus.atx_vld, 1'b1);
      if (k > 0) begin
        check($sformatf("rr_awvalid%0d", k), bus.m_awvalid_o, 1'b1);
        check($sformatf("rr_awaddr%0d", k), bus.m_awaddr_o, addr_of((k - 1) % 4));
        check($sformatf("rr_wrdy%0d", k), bus.ch_wdata_rdy, onehot((k - 1) % 4));
      end
      tick();
    end
    bus.ch_req_vld = '0;
    settle();
    check("rr_tail_awvalid", bus.m_awvalid_o, 1'b1);
    check("rr_tail_atx_vld", bus.atx_vld, 1'b0);
    tick();
    settle();
    check("rr_idle", bus.wr_idle, 1'b1);

    // Order preservation: ch2 len=3 then ch0 len=1.
    bus.ch_req_vld = 4'b0100;
    set_len(2, 8'd3);
    settle();
    check("ord_gnt2", bus.ch_req_rdy, 4'b0100);
    check("ord_len2", bus.atx_awlen, 8'd3);
    tick();
    bus.ch_req_vld = 4'b0001;
    set_len(0, 8'd1);
    settle();
    check("ord_gnt0", bus.ch_req_rdy, 4'b0001);
    check("ord_len0", bus.atx_awlen, 8'd1);
    check("ord_b0_wrdy", bus.ch_wdata_rdy, 4'b0100);
    check("ord_b0_data", bus.atx_wdata, data_of(2));
    tick();
    bus.ch_req_vld = '0;
    for (int b = 1; b < 4; b++) begin
      settle();
      check($sformatf("ord_ch2_wrdy%0d", b), bus.ch_wdata_rdy, 4'b0100);
      check($sformatf("ord_ch2_vld%0d", b), bus.atx_wdata_vld, 1'b1);
      tick();
    end
    for (int b = 0; b < 2; b++) begin
      settle();
      check($sformatf("ord_ch0_wrdy%0d", b), bus.ch_wdata_rdy, 4'b0001);
      check($sformatf("ord_ch0_data%0d", b), bus.atx_wdata, data_of(0));
      tick();
    end
    settle();
    check("ord_idle", bus.wr_idle, 1'b1);
    set_len(0, 8'd0);
    set_len(2, 8'd0);

    // Outstanding limit: W stalled, exactly 4 issues starting from rr_ptr=1.
    bus.atx_wdata_rdy = 1'b0;
    bus.ch_req_vld    = 4'hF;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("ostd_gnt%0d", k), bus.ch_req_rdy, onehot((k + 1) % 4));
      tick();
    end
    settle();
    check("ostd_full_rdy", bus.ch_req_rdy, 4'b0000);
    check("ostd_full_atx", bus.atx_vld, 1'b0);
    tick();
    bus.atx_wdata_rdy = 1'b1;
    settle();
    check("ostd_pop_blocks", bus.ch_req_rdy, 4'b0000);
    check("ostd_pop_head", bus.ch_wdata_rdy, onehot(1));
    tick();
    bus.atx_wdata_rdy = 1'b0;
    settle();
    check("ostd_reissue", bus.ch_req_rdy, onehot(1));
    tick();
    bus.ch_req_vld    = '0;
    bus.atx_wdata_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("ostd_drain%0d", k), bus.ch_wdata_rdy, onehot((k + 2) % 4));
      tick();
    end
    settle();
    check("ostd_idle", bus.wr_idle, 1'b1);

    // AW backpressure: ch2 len=5 held while ch0 waits.
    bus.ch_wdata_vld = '0;
    bus.ch_req_vld   = 4'b0100;
    set_len(2, 8'd5);
    settle();
    check("aw_gnt2", bus.ch_req_rdy, 4'b0100);
    tick();
    bus.m_awready_i = 1'b0;
    bus.ch_req_vld  = 4'b0001;
    set_len(0, 8'd7);
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("aw_hold_atx%0d", k), bus.atx_vld, 1'b0);
      check($sformatf("aw_hold_rdy%0d", k), bus.ch_req_rdy, 4'b0000);
      check($sformatf("aw_hold_valid%0d", k), bus.m_awvalid_o, 1'b1);
      check($sformatf("aw_hold_addr%0d", k), bus.m_awaddr_o, addr_of(2));
      check($sformatf("aw_hold_len%0d", k), bus.m_awlen_o, 8'd5);
      tick();
    end
    bus.m_awready_i = 1'b1;
    settle();
    check("aw_rel_atx", bus.atx_vld, 1'b1);
    check("aw_rel_gnt0", bus.ch_req_rdy, 4'b0001);
    check("aw_rel_len", bus.atx_awlen, 8'd7);
    tick();
    bus.ch_req_vld = '0;
    settle();
    check("aw_new_addr", bus.m_awaddr_o, addr_of(0));
    check("aw_new_len", bus.m_awlen_o, 8'd7);
    tick();
    bus.ch_wdata_vld = 4'hF;
    for (int b = 0; b < 14; b++) begin
      settle();
      check($sformatf("aw_drain%0d", b), bus.ch_wdata_rdy, (b < 6) ? 4'b0100 : 4'b0001);
      tick();
    end
    settle();
    check("aw_idle", bus.wr_idle, 1'b1);
    set_len(0, 8'd0);
    set_len(2, 8'd0);

    // W engine full: no grant, pointer and FIFO untouched.
    bus.atx_rdy    = 1'b0;
    bus.ch_req_vld = 4'hF;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("wf_rdy%0d", k), bus.ch_req_rdy, 4'b0000);
      check($sformatf("wf_atx%0d", k), bus.atx_vld, 1'b0);
      check($sformatf("wf_awvalid%0d", k), bus.m_awvalid_o, 1'b0);
      check($sformatf("wf_idle%0d", k), bus.wr_idle, 1'b1);
      tick();
    end
    bus.atx_rdy = 1'b1;
    set_len(1, 8'd3);
    settle();
    check("wf_rel_gnt1", bus.ch_req_rdy, onehot(1));
    tick();
    bus.ch_req_vld = '0;
    settle();
    check("mid_b0_wrdy", bus.ch_wdata_rdy, onehot(1));
    check("mid_b0_vld", bus.atx_wdata_vld, 1'b1);
    tick();

    // Reset in the middle of the ch1 burst.
    rst_n = 1'b0;
    settle();
    check_reset("mid");
    tick();
    rst_n          = 1'b1;
    bus.ch_req_vld = 4'hF;
    set_len(0, 8'd1);
    settle();
    check("post_rst_gnt0", bus.ch_req_rdy, 4'b0001);
    tick();
    bus.ch_req_vld = '0;
    settle();
    check("post_rst_b0", bus.ch_wdata_rdy, 4'b0001);
    check("post_rst_data", bus.atx_wdata, data_of(0));
    tick();
    settle();
    check("post_rst_b1", bus.ch_wdata_rdy, 4'b0001);
    tick();
    settle();
    check("post_rst_empty", bus.ch_wdata_rdy, 4'b0000);
    check("post_rst_idle", bus.wr_idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adma_dm_wr_sched.md
# adma_dm_wr_sched

Write-side scheduler for the DMA data mover. It round-robin arbitrates write-transaction requests from `CH_NUM` channels and issues the AW beat for the winner. It pushes the burst length to the W engine's transaction buffer and steers the owning channel's data buffer onto the shared W datapath, in issue order. It sits between the per-channel descriptor/data-buffer logic and the AW register plus W engine of the AXI master.

## Interface
- `CH_NUM`, 4: number of requesting channels (≥2).
- `CH_ID_W`, 2: channel index width; equals clog2(`CH_NUM`).
- `ATX_ADDR_W`, 32: AXI address width.
- `ATX_LEN_W`, 8: AXI AWLEN width.
- `ATX_DST_DATA_W`, 256: W data width.
- `ATX_NUM_OSTD`, 4: order-FIFO depth, i.e. max issued-but-not-fully-written transactions.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ch_req_vld`  in  `CH_NUM`  per-channel write request valid.
- `ch_req_addr`  in  `CH_NUM*ATX_ADDR_W`  request AWADDR, packed; channel i is at slice [i*W +: W].
- `ch_req_len`  in  `CH_NUM*ATX_LEN_W`  request AWLEN (beats-1), packed.
- `ch_req_rdy`  out  `CH_NUM`  one-hot request accept.
- `ch_wdata`  in  `CH_NUM*ATX_DST_DATA_W`  per-channel data-buffer output, packed.
- `ch_wdata_vld`  in  `CH_NUM`  per-channel data valid.
- `ch_wdata_rdy`  out  `CH_NUM`  per-channel data pop.
- `m_awaddr_o`  out  `ATX_ADDR_W`  AXI AWADDR.
- `m_awlen_o`  out  `ATX_LEN_W`  AXI AWLEN.
- `m_awvalid_o`  out  1  AXI AWVALID.
- `m_awready_i`  in  1  AXI AWREADY.
- `atx_awlen`  out  `ATX_LEN_W`  length pushed to the W engine.
- `atx_vld`  out  1  length push valid.
- `atx_rdy`  in  1  W engine length-buffer ready.
- `atx_wdata`  out  `ATX_DST_DATA_W`  steered write data.
- `atx_wdata_vld`  out  1  steered data valid.
- `atx_wdata_rdy`  in  1  W engine data ready.
- `wr_idle`  out  1  high when nothing is issued or pending.

## Operation
- **Issue condition** (`issue`) requires all of the following:
  - at least one `ch_req_vld` bit is set;
  - the AW slot is free (`!m_awvalid_o || m_awready_i`);
  - `atx_rdy` is high;
  - the order FIFO is not full.
- **Full FIFO:** a full order FIFO blocks issue even if it is popping in the same cycle.
- **Arbitration:** round-robin over `ch_req_vld`. Search starts at `rr_ptr`; the first set bit wins (`gnt_id`).
  - On `issue`, `rr_ptr` becomes `gnt_id+1` mod `CH_NUM`.
  - `rr_ptr` holds without `issue`.
- **On `issue` (same cycle, combinational):**
  - `ch_req_rdy[gnt_id]=1` and all other `ch_req_rdy` bits are 0;
  - `atx_vld=1` and `atx_awlen=ch_req_len[gnt_id]`;
  - `atx_vld` is never high without `issue`.
- **On `issue` (registered):**
  - the AW register loads the address and length, and `m_awvalid_o` is set;
  - the order FIFO pushes {`gnt_id`, len}.
- **AW register:** `m_awvalid_o` clears on `m_awready_i` when there is no simultaneous `issue`. Address and length are stable while `m_awvalid_o && !m_awready_i`.
- **Data steering:** let the order-FIFO head be {`hid`, `hlen`} and `hv` = FIFO non-empty.
  - `atx_wdata = ch_wdata[hid]`.
  - `atx_wdata_vld = hv & ch_wdata_vld[hid]`.
  - `ch_wdata_rdy[hid] = hv & atx_wdata_rdy`; all other bits are 0. When `!hv`, all bits are 0.
- **Beat counter** (`beat_cnt`, `ATX_LEN_W` bits) increments on each data handshake (`atx_wdata_vld & atx_wdata_rdy`).
  - When `beat_cnt == hlen` on a handshake, the counter clears and the FIFO pops.
  - With len=0, a transaction takes one beat and pops immediately.
- **Idle:** `wr_idle = FIFO empty & !m_awvalid_o`.
- **Reset values:** `m_awvalid_o=0`, `m_awaddr_o=0`, `m_awlen_o=0`, `rr_ptr=0`, `beat_cnt=0`, FIFO empty. Consequently all `ch_req_rdy`/`ch_wdata_rdy` are 0, `atx_vld=0`, `atx_wdata_vld=0`, `wr_idle=1`.
- **Reset mid-operation:** all in-flight transactions are discarded; nothing is preserved.

## Timing
- **Request to AW:** a request accepted in cycle N gives `m_awvalid_o` high in cycle N+1.
- **Request to data:** the channel's data is steerable from cycle N+1, because the FIFO write is registered. W may precede AW acceptance.
- **Back-to-back issue:** one issue per cycle is sustained while `m_awready_i=1`. The AW register is written in the same cycle its old content is accepted.
- **Data throughput:** one beat per cycle. The boundary between consecutive transactions incurs no bubble; the next head is selected in the cycle after the pop.
- **Simultaneous FIFO push and pop:** legal when the FIFO is not full; the count is unchanged.

## Test plan
1. **Reset state.** Assert `rst_n`=0 mid-burst. Required: all outputs are at their reset values, `wr_idle`=1, and the first post-reset grant goes to ch0.
2. **Round-robin fairness.** All 4 channels request continuously, len=0, `m_awready_i`=1, W always ready. Required: grants follow 0,1,2,3,0…, one per cycle, and `m_awvalid_o` is high continuously.
3. **Order preservation.** Ch2 issues len=3, then ch0 issues len=1. Data is offered on both channels. Required: 4 beats from ch2 reach `atx_wdata` first, then 2 beats from ch0; no `ch_wdata_rdy[0]` is asserted before the 4th ch2 handshake.
4. **Outstanding limit.** `m_awready_i`=1 and `atx_wdata_rdy`=0. Required: exactly 4 issues, then `ch_req_rdy`=0. After one transaction completes, the next issue occurs one cycle later.
5. **AW backpressure.** `m_awready_i`=0 for 5 cycles. Required: `m_awaddr_o`/`m_awlen_o` are stable, no second issue occurs, and `atx_vld` stays 0 until the cycle `m_awready_i`=1.
6. **W engine full.** `atx_rdy`=0 with requests pending. Required: no grant, `rr_ptr` unchanged, and the FIFO is unchanged.
